uart_rx_fifo: RTL and testbench

Receive-side byte buffer directly downstream of the 8-bit UART receiver, clocked by the same 16x-oversampled rx clock. It detects the rising edge of the receiver's multi-cycle `done` pulse, captures the byte once, and queues it in a FIFO. The FIFO is read through a first-word-fall-through valid/ready port. The block also tracks overrun and counts receive errors (rising edges of `err`) for status software.

---
 rtl/uart_rx_fifo.sv | 104 ++++++++++
 tb/tb_uart_rx_fifo.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: edge-detects the receiver's
// done/err levels, queues one byte per done pulse, and exposes a FWFT read port.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  clr_status,
  input  logic                  rx_done,
  input  logic                  rx_err,
  input  logic [7:0]            rx_data,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  overrun,
  output logic [7:0]            err_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;
  logic                  done_q;
  logic                  err_q;
  logic                  push_req;
  logic                  err_rise;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign full     = (level == LEVEL_FULL);
  assign rd_valid = (level != '0);
  assign rd_data  = rd_valid ? mem[rp] : '0;

  // Edge registers reset high so a pulse already asserted at reset release is ignored.
  assign push_req = rx_done & ~done_q;
  assign err_rise = rx_err & ~err_q;
  assign pop      = rd_valid & rd_ready;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wp] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b1;
      err_q  <= 1'b1;
    end else begin
      done_q <= rx_done;
      err_q  <= rx_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (clear) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      err_count <= '0;
    end else if (clr_status) begin
      overrun   <= 1'b0;
      err_count <= '0;
    end else begin
      if (drop) begin
        overrun <= 1'b1;
      end
      if (err_rise && err_count != 8'hFF) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clear = 1'b0;
  logic           clr_status = 1'b0;
  logic           rx_done = 1'b0;
  logic           rx_err = 1'b0;
  logic [7:0]     rx_data = '0;
  logic [7:0]     rd_data;
  logic           rd_valid;
  logic           rd_ready = 1'b0;
  logic [DL2:0]   level;
  logic           full;
  logic           overrun;
  logic [7:0]     err_count;

  int total = 0;
  int bad = 0;

  // reference model
  logic [7:0] mq[$];
  logic       m_done_prev;
  logic       m_err_prev;
  logic       m_ov;
  int         m_ec;

  uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .clr_status(clr_status),
    .rx_done(rx_done), .rx_err(rx_err), .rx_data(rx_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .level(level), .full(full), .overrun(overrun), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_head();
    return (mq.size() != 0) ? mq[0] : 8'h00;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_done_prev = 1'b1;
    m_err_prev  = 1'b1;
    m_ov        = 1'b0;
    m_ec        = 0;
  endtask

  // One clock: the model consumes the inputs seen at the edge, then outputs settle.
  task automatic tick();
    logic new_byte, new_err, took, dropped;
    @(posedge clk);
    if (rst_n) begin
      new_byte = rx_done && !m_done_prev;
      new_err  = rx_err && !m_err_prev;
      took     = (mq.size() != 0) && rd_ready;
      dropped  = new_byte && (mq.size() == DEPTH) && !took;
      if (clear) begin
        mq.delete();
      end else begin
        if (took) void'(mq.pop_front());
        if (new_byte && mq.size() < DEPTH) mq.push_back(rx_data);
      end
      if (clr_status) begin
        m_ov = 1'b0;
        m_ec = 0;
      end else begin
        if (dropped) m_ov = 1'b1;
        if (new_err && m_ec < 255) m_ec++;
      end
      m_done_prev = rx_done;
      m_err_prev  = rx_err;
    end
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input int hi, input int lo);
    rx_data = d;
    rx_done = 1'b1;
    repeat (hi) tick();
    rx_done = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", rd_valid); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_data got %h want 00", rd_data); end
    total++; if (level !== '0) begin bad++; $display("FAIL reset_level got %0d want 0", level); end
    total++; if ({full, overrun} !== 2'b00) begin bad++; $display("FAIL reset_flags got %b want 00", {full, overrun}); end
    total++; if (err_count !== 8'h00) begin bad++; $display("FAIL reset_errcnt got %h want 00", err_count); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int extra = 0;
    rd_ready = 1'b0;
    rx_data  = 8'hA5;
    rx_done  = 1'b1;
    tick();
    total++; if (level !== 5'd1) begin bad++; $display("FAIL single_level got %0d want 1", level); end
    total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL single_data got %h want a5", rd_data); end
    for (int i = 1; i < 16; i++) begin
      tick();
      if (level !== 5'd1) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL single_one_push got %0d bad cycles want 0", extra); end
    rx_done  = 1'b0;
    tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    total++; if (level !== '0) begin bad++; $display("FAIL single_pop_level got %0d want 0", level); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL single_pop_data got %h want 00", rd_data); end
  endtask

  task automatic test_fill_wrap();
    rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 4, 2);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL wrap_full got %b want 1", full); end
    total++; if (level !== 5'd16) begin bad++; $display("FAIL wrap_level got %0d want 16", level); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rd_data !== 8'(i)) begin bad++; $display("FAIL wrap_pop got %h want %h", rd_data, 8'(i)); end
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i), 3, 2);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (rd_data !== 8'(i + 4)) begin bad++; $display("FAIL wrap_order got %h want %h", rd_data, 8'(i + 4)); end
      tick();
    end
    rd_ready = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty got %b want 0", rd_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL wrap_overrun got %b want 0", overrun); end
  endtask

  task automatic test_overrun();
    int guard = 0;
    rd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 8'hED)), 2, 1);
    send_byte(8'hEE, 5, 1);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got %b want 1", overrun); end
    total++; if (level !== 5'd16) begin bad++; $display("FAIL ovr_level got %0d want 16", level); end
    rd_ready = 1'b1;
    while (mq.size() != 0 && guard < 40) begin
      total++; if (rd_data === 8'hEE || rd_data !== m_head()) begin bad++; $display("FAIL ovr_drain got %h want %h", rd_data, m_head()); end
      tick();
      guard++;
    end
    rd_ready = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL ovr_empty got %b want 0", rd_valid); end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got %b want 0", overrun); end
  endtask

  task automatic test_full_pop();
    logic [7:0] second, newb;
    int guard = 0;
    rd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 2, 1);
    second = mq[1];
    newb = 8'($urandom);
    rx_data  = newb;
    rx_done  = 1'b1;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    total++; if (level !== 5'd16) begin bad++; $display("FAIL fullpop_level got %0d want 16", level); end
    total++; if (rd_data !== second) begin bad++; $display("FAIL fullpop_head got %h want %h", rd_data, second); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL fullpop_overrun got %b want 0", overrun); end
    repeat (3) tick();
    rx_done = 1'b0;
    tick();
    rd_ready = 1'b1;
    while (level > 1 && guard < 40) begin tick(); guard++; end
    total++; if (rd_data !== newb || level !== 5'd1) begin bad++; $display("FAIL fullpop_tail got %h lvl %0d want %h lvl 1", rd_data, level, newb); end
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_err();
    for (int i = 0; i < 300; i++) begin
      rx_err = 1'b1;
      repeat (20) tick();
      rx_err = 1'b0;
      repeat (2) tick();
    end
    total++; if (err_count !== 8'hFF || m_ec != 255) begin bad++; $display("FAIL err_saturate got %h want ff", err_count); end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    rx_err = 1'b1;
    repeat (30) tick();
    total++; if (err_count !== 8'h01) begin bad++; $display("FAIL err_held got %h want 01", err_count); end
    rx_err = 1'b0;
    tick();
    rx_err = 1'b1;
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    repeat (5) tick();
    total++; if (err_count !== 8'h00) begin bad++; $display("FAIL err_clr_rise got %h want 00", err_count); end
    rx_err = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 2, 1);
    rx_err = 1'b1;
    tick();
    rx_err = 1'b0;
    rx_data = 8'h77;
    rx_done = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++; if ({rd_valid, full, overrun} !== 3'b000 || level !== '0) begin bad++; $display("FAIL rstmid_state got v%b f%b o%b l%0d want all 0", rd_valid, full, overrun, level); end
    total++; if (rd_data !== 8'h00 || err_count !== 8'h00) begin bad++; $display("FAIL rstmid_data got %h/%h want 00/00", rd_data, err_count); end
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    total++; if (level !== '0 || rd_valid !== 1'b0) begin bad++; $display("FAIL rstmid_nopush got lvl %0d want 0", level); end
    rx_done = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    rd_ready = 1'b0;
    send_byte(8'h31, 2, 1);
    send_byte(8'h32, 2, 1);
    rx_data = 8'h33;
    rx_done = 1'b1;
    clear   = 1'b1;
    tick();
    clear   = 1'b0;
    total++; if (level !== '0 || rd_valid !== 1'b0) begin bad++; $display("FAIL clear_push got lvl %0d v%b want 0/0", level, rd_valid); end
    repeat (3) tick();
    rx_done = 1'b0;
    tick();
    total++; if (level !== '0) begin bad++; $display("FAIL clear_hold got lvl %0d want 0", level); end
  endtask

  task automatic test_random();
    int hi, lo, errs;
    errs = 0;
    for (int p = 0; p < 150; p++) begin
      hi = $urandom_range(1, 16);
      lo = $urandom_range(1, 5);
      rx_data = 8'($urandom);
      for (int c = 0; c < hi + lo; c++) begin
        rx_done    = (c < hi);
        rd_ready   = ($urandom_range(0, 99) < 20);
        if ($urandom_range(0, 9) == 0) rx_err = ~rx_err;
        clr_status = ($urandom_range(0, 199) == 0);
        clear      = ($urandom_range(0, 299) == 0);
        tick();
        total++;
        if (rd_data !== m_head() || level !== (DL2+1)'(mq.size()) || full !== (mq.size() == DEPTH)
            || overrun !== m_ov || err_count !== 8'(m_ec)) begin
          bad++;
          errs++;
          if (errs < 10)
            $display("FAIL random got d%h l%0d f%b o%b e%h want d%h l%0d f%b o%b e%h",
                     rd_data, level, full, overrun, err_count,
                     m_head(), mq.size(), (mq.size() == DEPTH), m_ov, 8'(m_ec));
        end
      end
    end
    rx_done = 1'b0; rd_ready = 1'b0; clear = 1'b0; clr_status = 1'b0; rx_err = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_wrap();
    test_overrun();
    test_full_pop();
    test_err();
    test_reset_mid();
    test_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
